fc_layer_ctrl: RTL and testbench

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

---
 rtl/fc_layer_ctrl.sv | 154 +++++++++++++++
 tb/tb_fc_layer_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// ---------------------------------------------------------------------------
// fc_layer_ctrl
//
// Sequencer for one fully-connected layer. It accepts one input vector, then
// for each output neuron it walks the input words through a multiply-
// accumulate unit and writes the finished neuron value to an output FIFO.
//
// Parameters
//   LAYER_HEIGHT  input words per vector (MAC cycles per neuron)
//   NUM_OUTPUTS   output neurons computed per vector
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-low reset
//   valid_i        upstream vector valid
//   ready_o        controller idle and able to take a vector
//   latch_o        datapath captures the input vector this cycle
//   in_sel_o       input word select for the MAC
//   weight_addr_o  weight memory address (neuron*LAYER_HEIGHT + word)
//   mac_clr_o      MAC loads the product instead of accumulating
//   mac_en_o       MAC update enable
//   wen_o          output FIFO write enable
//   full_i         output FIFO full (stalls the write)
//   neuron_o       current neuron index
//   busy_o         vector in progress
//   done_o         one-cycle pulse on the final neuron write
// ---------------------------------------------------------------------------
module fc_layer_ctrl #(
  parameter int LAYER_HEIGHT = 4,
  parameter int NUM_OUTPUTS  = 8,
  localparam int IDX_W  = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1,
  localparam int NEU_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
  localparam int ADDR_W = ((NUM_OUTPUTS * LAYER_HEIGHT) > 1) ?
                          $clog2(NUM_OUTPUTS * LAYER_HEIGHT) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              latch_o,
  output logic [IDX_W-1:0]  in_sel_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              wen_o,
  input  logic              full_i,
  output logic [NEU_W-1:0]  neuron_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LAYER_HEIGHT - 1);
  localparam logic [NEU_W-1:0]  NEU_LAST = NEU_W'(NUM_OUTPUTS - 1);
  localparam logic [ADDR_W-1:0] LH_A     = ADDR_W'(LAYER_HEIGHT);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_next_idx;
  logic [NEU_W-1:0] r_neuron;
  logic [NEU_W-1:0] w_next_neuron;
  logic             w_accept;

  // State and counter registers. Reset drops straight back to IDLE, which
  // aborts any vector in flight so no further FIFO writes can occur.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_neuron <= '0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_neuron <= w_next_neuron;
    end
  end

  // A vector is only taken while idle. Gating with reset keeps latch_o low
  // while reset is held even though the idle state already reports ready.
  assign w_accept = valid_i & reset_i;

  // Next-state and output decode. In MAC the word index sweeps once per
  // neuron; WRITE holds everything while the FIFO is full, so a stall freezes
  // the sequence without disturbing the counters.
  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_neuron = r_neuron;
    ready_o       = 1'b0;
    latch_o       = 1'b0;
    in_sel_o      = r_idx;
    weight_addr_o = '0;
    mac_clr_o     = 1'b0;
    mac_en_o      = 1'b0;
    wen_o         = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;

    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept) begin
          latch_o       = 1'b1;
          w_next_state  = S_MAC;
          w_next_idx    = '0;
          w_next_neuron = '0;
        end
      end

      S_MAC: begin
        busy_o        = 1'b1;
        mac_en_o      = 1'b1;
        mac_clr_o     = (r_idx == '0);
        weight_addr_o = ADDR_W'(r_neuron) * LH_A + ADDR_W'(r_idx);
        if (r_idx == IDX_LAST) begin
          w_next_idx   = '0;
          w_next_state = S_WRITE;
        end else begin
          w_next_idx = r_idx + IDX_W'(1);
        end
      end

      S_WRITE: begin
        busy_o = 1'b1;
        if (!full_i) begin
          wen_o = 1'b1;
          if (r_neuron == NEU_LAST) begin
            done_o        = 1'b1;
            w_next_neuron = '0;
            w_next_state  = S_IDLE;
          end else begin
            w_next_neuron = r_neuron + NEU_W'(1);
            w_next_state  = S_MAC;
          end
        end
      end

      default: begin
        w_next_state  = S_IDLE;
        w_next_idx    = '0;
        w_next_neuron = '0;
      end
    endcase
  end

  assign neuron_o = r_neuron;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_ctrl
//
// Two controller instances: A (LAYER_HEIGHT=4, NUM_OUTPUTS=3) and
// B (LAYER_HEIGHT=1, NUM_OUTPUTS=2). For every vector the stimulus
// computes the expected latch, MAC and write events (with absolute cycle
// numbers) from the layer arithmetic and pushes them into per-instance
// queues; a monitor on the falling edge pops and compares whenever an
// instance shows latch_o, mac_en_o or wen_o, and checks the per-cycle
// invariants.
// ---------------------------------------------------------------------------
module tb_fc_layer_ctrl;

  typedef struct {
    int cyc;
    int addr;
    int sel;
    int clr;
  } mevt_t;

  typedef struct {
    int cyc;
    int neuron;
    int done;
  } wevt_t;

  logic clk_i = 1'b0;
  logic reset_i;
  logic validA, validB, fullA, fullB;

  logic       readyA, latchA, clrA, enA, wenA, busyA, doneA;
  logic [1:0] selA;
  logic [3:0] addrA;
  logic [1:0] neuA;
  logic       readyB, latchB, clrB, enB, wenB, busyB, doneB;
  logic [0:0] selB;
  logic [0:0] addrB;
  logic [0:0] neuB;

  int cyc = 0;
  int nCompared = 0;
  int nMismatch = 0;

  int    qlA[$];
  int    qlB[$];
  mevt_t qmA[$];
  mevt_t qmB[$];
  wevt_t qwA[$];
  wevt_t qwB[$];

  fc_layer_ctrl #(.LAYER_HEIGHT(4), .NUM_OUTPUTS(3)) dA (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(validA), .ready_o(readyA),
    .latch_o(latchA), .in_sel_o(selA), .weight_addr_o(addrA),
    .mac_clr_o(clrA), .mac_en_o(enA), .wen_o(wenA), .full_i(fullA),
    .neuron_o(neuA), .busy_o(busyA), .done_o(doneA)
  );

  fc_layer_ctrl #(.LAYER_HEIGHT(1), .NUM_OUTPUTS(2)) dB (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(validB), .ready_o(readyB),
    .latch_o(latchB), .in_sel_o(selB), .weight_addr_o(addrB),
    .mac_clr_o(clrB), .mac_en_o(enB), .wen_o(wenB), .full_i(fullB),
    .neuron_o(neuB), .busy_o(busyB), .done_o(doneB)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One falling-edge observation of one instance.
  task automatic monitorStep(input int s, input logic latch, input logic en,
                             input logic clr, input logic wen, input logic done,
                             input logic ready, input logic busy, input int addr,
                             input int sel, input int neu);
    int    lc;
    int    qs;
    mevt_t m;
    wevt_t w;
    string p;
    p = (s == 0) ? "A." : "B.";
    if (latch) begin
      qs = (s == 0) ? qlA.size() : qlB.size();
      if (qs == 0) checkOutput({p, "unexpected_latch"}, int'(latch), 0);
      else begin
        lc = (s == 0) ? qlA.pop_front() : qlB.pop_front();
        checkOutput({p, "latch_cycle"}, cyc, lc);
      end
    end
    if (en) begin
      qs = (s == 0) ? qmA.size() : qmB.size();
      if (qs == 0) checkOutput({p, "unexpected_mac_en"}, int'(en), 0);
      else begin
        m = (s == 0) ? qmA.pop_front() : qmB.pop_front();
        checkOutput({p, "mac_cycle"}, cyc, m.cyc);
        checkOutput({p, "weight_addr"}, addr, m.addr);
        checkOutput({p, "in_sel"}, sel, m.sel);
        checkOutput({p, "mac_clr"}, int'(clr), m.clr);
      end
    end else begin
      checkOutput({p, "addr_outside_mac"}, addr, 0);
      checkOutput({p, "clr_outside_mac"}, int'(clr), 0);
    end
    if (wen) begin
      qs = (s == 0) ? qwA.size() : qwB.size();
      if (qs == 0) checkOutput({p, "unexpected_wen"}, int'(wen), 0);
      else begin
        w = (s == 0) ? qwA.pop_front() : qwB.pop_front();
        checkOutput({p, "wen_cycle"}, cyc, w.cyc);
        checkOutput({p, "neuron"}, neu, w.neuron);
        checkOutput({p, "done"}, int'(done), w.done);
      end
    end else begin
      checkOutput({p, "done_without_wen"}, int'(done), 0);
    end
    checkOutput({p, "mac_en_and_wen"}, int'(en & wen), 0);
    checkOutput({p, "busy_vs_ready"}, int'(busy), int'(!ready));
  endtask

  always @(negedge clk_i) begin
    if (reset_i === 1'b1) begin
      monitorStep(0, latchA, enA, clrA, wenA, doneA, readyA, busyA,
                  int'(addrA), int'(selA), int'(neuA));
      monitorStep(1, latchB, enB, clrB, wenB, doneB, readyB, busyB,
                  int'(addrB), int'(selB), int'(neuB));
    end
  end

  task automatic drive(input int s, input logic v, input logic f);
    if (s == 0) begin
      validA = v; fullA = f; validB = 1'b0; fullB = 1'(($urandom % 2));
    end else begin
      validB = v; fullB = f; validA = 1'b0; fullA = 1'(($urandom % 2));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1'b0, 1'(($urandom % 2)));
      validB = 1'b0;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic clearQueues();
    qlA.delete(); qlB.delete(); qmA.delete(); qmB.delete();
    qwA.delete(); qwB.delete();
  endtask

  // Issue one vector to instance s starting this cycle. stallFirst >= 0 puts
  // that many full cycles on the first write only; -1 randomises all stalls.
  // abortAt >= 0 pulls reset in that cycle offset after checking weight_addr.
  task automatic applyStimulus(input int s, input bit hold, input int stallFirst,
                               input int abortAt, input int abortAddr);
    int    lh, no, L, base, w;
    int    stall[];
    bit    fsched[];
    mevt_t m;
    wevt_t we;
    lh = (s == 0) ? 4 : 1;
    no = (s == 0) ? 3 : 2;
    stall = new[no];
    for (int n = 0; n < no; n++)
      stall[n] = (stallFirst >= 0) ? ((n == 0) ? stallFirst : 0) : int'($urandom_range(0, 3));
    w = 0;
    for (int n = 0; n < no; n++) w += lh + 1 + stall[n];
    fsched = new[w + 1];
    for (int c = 0; c <= w; c++) fsched[c] = 1'(($urandom % 2));
    L = cyc;
    if (s == 0) qlA.push_back(L); else qlB.push_back(L);
    base = 0;
    for (int n = 0; n < no; n++) begin
      for (int i = 0; i < lh; i++) begin
        m.cyc = L + base + 1 + i; m.addr = n * lh + i; m.sel = i; m.clr = (i == 0);
        if (s == 0) qmA.push_back(m); else qmB.push_back(m);
      end
      for (int k = 0; k < stall[n]; k++) fsched[base + lh + 1 + k] = 1'b1;
      base = base + lh + 1 + stall[n];
      fsched[base] = 1'b0;
      we.cyc = L + base; we.neuron = n; we.done = (n == no - 1);
      if (s == 0) qwA.push_back(we); else qwB.push_back(we);
    end
    for (int c = 0; c <= base; c++) begin
      drive(s, (c == 0) || hold, fsched[c]);
      if (c == abortAt) begin
        checkOutput("A.addr_before_reset", int'(addrA), abortAddr);
        validA = 1'b1;
        reset_i = 1'b0;
        clearQueues();
        #1;
        checkOutput("rst.mac_en", int'(enA), 0);
        checkOutput("rst.mac_clr", int'(clrA), 0);
        checkOutput("rst.weight_addr", int'(addrA), 0);
        checkOutput("rst.wen", int'(wenA), 0);
        checkOutput("rst.done", int'(doneA), 0);
        checkOutput("rst.latch", int'(latchA), 0);
        checkOutput("rst.neuron", int'(neuA), 0);
        checkOutput("rst.ready", int'(readyA), 1);
        checkOutput("rst.busy", int'(busyA), 0);
        @(posedge clk_i); #1;
        validA = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        return;
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #2_000_000;
    nMismatch++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hold;
    reset_i = 1'b0;
    validA = 1'b1; validB = 1'b1; fullA = 1'b0; fullB = 1'b0;
    #12;
    checkOutput("reset.A.ready", int'(readyA), 1);
    checkOutput("reset.A.busy", int'(busyA), 0);
    checkOutput("reset.A.latch", int'(latchA), 0);
    checkOutput("reset.B.ready", int'(readyB), 1);
    checkOutput("reset.B.latch", int'(latchB), 0);
    checkOutput("reset.B.mac_en", int'(enB), 0);
    @(posedge clk_i); #1;
    validA = 1'b0; validB = 1'b0;
    reset_i = 1'b1;
    idleCycles(2);

    // Nominal vector, then first-write back-pressure of 3 cycles.
    applyStimulus(0, 1'b0, 0, -1, 0);
    idleCycles(2);
    applyStimulus(0, 1'b0, 3, -1, 0);
    idleCycles(1);
    // valid held through a whole vector: next latch right after done.
    applyStimulus(0, 1'b1, 0, -1, 0);
    applyStimulus(0, 1'b0, 0, -1, 0);
    idleCycles(2);
    // Reset while weight_addr = 6 (neuron 1, word 2 -> offset 8), then restart.
    applyStimulus(0, 1'b0, 0, 8, 6);
    idleCycles(1);
    applyStimulus(0, 1'b0, 0, -1, 0);
    idleCycles(2);
    // Single-word layer.
    applyStimulus(1, 1'b0, 0, -1, 0);
    idleCycles(1);
    applyStimulus(1, 1'b1, 0, -1, 0);
    applyStimulus(1, 1'b0, 2, -1, 0);
    idleCycles(2);

    // Randomised traffic on both instances.
    for (int v = 0; v < 40; v++) begin
      int s;
      s = (v < 20) ? 0 : 1;
      hold = (v != 19) && (v != 39) && (($urandom % 3) == 0);
      applyStimulus(s, hold, -1, -1, 0);
      if (!hold) idleCycles(int'($urandom_range(0, 3)));
    end

    idleCycles(6);
    checkOutput("A.pending_latch", qlA.size(), 0);
    checkOutput("A.pending_mac", qmA.size(), 0);
    checkOutput("A.pending_wen", qwA.size(), 0);
    checkOutput("B.pending_latch", qlB.size(), 0);
    checkOutput("B.pending_mac", qmB.size(), 0);
    checkOutput("B.pending_wen", qwB.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
